// File: rtl/concat_mac_seq_if.sv
// +----------------------------------------------------------------------------+
// | concat_mac_seq_if : operand/result handshake bundle for concat_mac_seq     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface concat_mac_seq_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         start;
  logic signed [DATA_WIDTH-1:0] bias;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic signed [DATA_WIDTH-1:0] in_weight;
  logic                         phase_h;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         busy;

  modport master (
    output start, bias, in_valid, in_data, in_weight, out_ready,
    input  in_ready, phase_h, out_valid, out_data, busy
  );

  modport slave (
    input  start, bias, in_valid, in_data, in_weight, out_ready,
    output in_ready, phase_h, out_valid, out_data, busy
  );
endinterface

`default_nettype wire

// File: rtl/concat_mac_seq.sv
// +----------------------------------------------------------------------------+
// | concat_mac_seq : sequential fixed-point MAC over concatenated [x ; h]      |
// | Optional macro SATURATE_EN clamps the result instead of wrapping. Rev 1.0  |
// +----------------------------------------------------------------------------+
`default_nettype none

module concat_mac_seq #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8,
  parameter int NUM_X       = 4,
  parameter int NUM_H       = 4,
  parameter int ACC_WIDTH   = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  concat_mac_seq_if.slave       bus
);

  localparam int c_total = NUM_X + NUM_H;
  localparam int c_cnt_w = $clog2(c_total + 1);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(c_total - 1);
  localparam logic [c_cnt_w-1:0] c_num_x = c_cnt_w'(NUM_X);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic        [c_cnt_w-1:0]     cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                          out_valid_q, out_valid_d;
  logic                          in_ready_q, in_ready_d;
  logic                          phase_h_q, phase_h_d;
  logic                          busy_q, busy_d;

  logic signed [2*DATA_WIDTH-1:0] prod_w;
  logic signed [2*DATA_WIDTH-1:0] prod_shift_w;
  logic signed [ACC_WIDTH-1:0]    prod_ext_w;
  logic signed [ACC_WIDTH-1:0]    acc_sum_w;
  logic signed [DATA_WIDTH-1:0]   result_w;
  logic                           beat_w;

  assign prod_w       = bus.in_data * bus.in_weight;
  assign prod_shift_w = prod_w >>> FRACT_WIDTH;
  assign prod_ext_w   = ACC_WIDTH'(prod_shift_w);
  assign acc_sum_w    = acc_q + prod_ext_w;
  assign beat_w       = bus.in_valid && in_ready_q;

`ifdef SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] c_sat_max =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] c_sat_min =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  always_comb begin
    result_w = acc_sum_w[DATA_WIDTH-1:0];
    if (acc_sum_w > c_sat_max) begin
      result_w = c_sat_max[DATA_WIDTH-1:0];
    end else if (acc_sum_w < c_sat_min) begin
      result_w = c_sat_min[DATA_WIDTH-1:0];
    end
  end
`else
  assign result_w = acc_sum_w[DATA_WIDTH-1:0];
`endif

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          acc_d   = ACC_WIDTH'(bus.bias);
          cnt_d   = '0;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        if (beat_w) begin
          acc_d = acc_sum_w;
          cnt_d = cnt_q + c_cnt_w'(1);
          // Result is captured on the final beat so out_valid rises next cycle.
          if (cnt_q == c_last) begin
            state_d    = ST_OUT;
            out_data_d = result_w;
          end
        end
      end
      ST_OUT: begin
        if (out_valid_q && bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered by decoding the next state.
    in_ready_d  = (state_d == ST_ACC);
    phase_h_d   = (state_d == ST_ACC) && (cnt_d >= c_num_x);
    out_valid_d = (state_d == ST_OUT);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      phase_h_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      phase_h_q   <= phase_h_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.phase_h   = phase_h_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;

endmodule

`default_nettype wire

// File: doc/concat_mac_seq.md
CONCAT_MAC_SEQ -- requirements
Module: concat_mac_seq

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the signed operand and result width.
REQ-002 The block SHALL have parameter FRACT_WIDTH, default 8, giving the fixed-point fraction bits.
REQ-003 The block SHALL have parameter NUM_X, default 4, giving the number of input-vector elements per result.
REQ-004 The block SHALL have parameter NUM_H, default 4, giving the number of hidden-state elements per result.
REQ-005 The block SHALL have parameter ACC_WIDTH, default 40, giving the signed accumulator width.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port start, input, 1 bit: begins a new result.
REQ-009 The block SHALL have port bias, input, DATA_WIDTH bits, signed: captured on the accepted start.
REQ-010 The block SHALL have port in_valid, input, 1 bit: an operand pair is present.
REQ-011 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand pair.
REQ-012 The block SHALL have port in_data, input, DATA_WIDTH bits, signed: x element, then h element.
REQ-013 The block SHALL have port in_weight, input, DATA_WIDTH bits, signed: matching weight.
REQ-014 The block SHALL have port phase_h, output, 1 bit: high while the next expected operand is an h element.
REQ-015 The block SHALL have port out_valid, output, 1 bit: out_data holds a result.
REQ-016 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-017 The block SHALL have port out_data, output, DATA_WIDTH bits, signed: the result.
REQ-018 The block SHALL have port busy, output, 1 bit: high in any state except IDLE.

Function
REQ-019 The block SHALL compute out = sum over k of ((in_data[k]*in_weight[k]) >>> FRACT_WIDTH) + bias, for k = 0..NUM_X+NUM_H-1, with x elements first, then h elements.
REQ-020 Each product SHALL be a full 2*DATA_WIDTH signed product, arithmetic-shifted right by FRACT_WIDTH, then sign-extended to ACC_WIDTH.
REQ-021 The FSM SHALL have states IDLE, ACC and OUT.
REQ-022 In IDLE, with start high: acc SHALL load sign-extended bias, the element counter SHALL clear, and the next state SHALL be ACC.
REQ-023 start SHALL be ignored in ACC and OUT.
REQ-024 in_ready SHALL be high only in ACC; a beat is accepted when in_valid && in_ready, and in_valid gaps SHALL stall accumulation without loss.
REQ-025 Each accepted beat SHALL add its product to acc and increment the counter.
REQ-026 On the beat accepted with counter == NUM_X+NUM_H-1, the next state SHALL be OUT, and out_data SHALL be registered from the final sum in that same edge.
REQ-027 out_valid SHALL rise in the cycle after the last beat is accepted.
REQ-028 phase_h SHALL be high when in ACC with counter >= NUM_X.
REQ-029 In OUT, out_valid and out_data SHALL hold stable until out_ready is high; on out_valid && out_ready the next state SHALL be IDLE.
REQ-030 The minimum period between results SHALL be NUM_X+NUM_H+2 cycles.

Reset
REQ-031 On rst: state SHALL be IDLE, and acc, counter and out_data SHALL be 0.
REQ-032 On rst: in_ready, out_valid, phase_h and busy SHALL be 0.
REQ-033 rst SHALL take priority over all other inputs; rst mid-ACC or mid-OUT SHALL discard the partial or pending result.

Configuration
REQ-034 With SATURATE_EN defined, out_data SHALL be acc clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-035 Without SATURATE_EN defined, out_data SHALL be acc[DATA_WIDTH-1:0], i.e. two's-complement wrap.

Verification (defaults, Q8.8)
REQ-036 start, bias=0, 8 beats in_data=0x0100, in_weight=0x0100 -> out_data=0x0800, with out_valid one cycle after the 8th beat.
REQ-037 bias=0x0100, 8 beats in_data=0xFF00 (-1.0), in_weight=0x0100 -> out_data=0xF900 (-1792).
REQ-038 8 beats of 0x7FFF*0x7FFF, bias=0 -> out_data=0x7FFF with SATURATE_EN, 0xF800 without it.
REQ-039 in_valid low 2 cycles between beats, and out_ready low 3 cycles -> same sum as REQ-036, out_data stable while stalled, phase_h high exactly for beats 4..7.
REQ-040 rst pulsed after 5 accepted beats, then a new REQ-036 sequence -> out_data=0x0800 with no residue; a start pulsed during ACC -> ignored.
